// File: rtl/i2c_slave_regif.sv
`timescale 1ns/1ps
// I2C register-file responder: decodes START/STOP, ACKs its address, emits register writes and serves reads.
// Latency: wr_valid 1 clock_sys after the synchronized SCL rise of data bit 0; SDA changes 1 cycle after a synced SCL fall.
// Backpressure: none; the I2C master paces every byte, and rd_data must be valid combinationally for rd_addr.
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock_sys,
  input  logic       reset_n,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       addr_hit
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_REG       = 4'd3;
  localparam logic [3:0] ST_REG_ACK   = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WDATA_ACK = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RD_MACK   = 4'd8;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  logic [3:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic [7:0] byte_in;
  logic [7:0] ptr;
  logic       rw;
  logic       sda_low;
  logic       last_bit;

  // Open-drain drive; reset gates the pull-down so the bus is freed the moment reset_n falls.
  assign i2c_sdat = (sda_low && reset_n) ? 1'b0 : 1'bz;

  assign rd_addr = ptr;

  // Synchronize SCL/SDA and keep one delayed copy for edge detection; idle bus reads as high.
  always_ff @(posedge clock_sys or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_sclk};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sdat};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in   = {shift[6:0], sda_s};
  assign last_bit  = (bit_cnt == 3'd7);

  // Protocol state machine: bus conditions first, then per-state bit handling on SCL edges.
  always_ff @(posedge clock_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      ptr      <= 8'h00;
      rw       <= 1'b0;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
      addr_hit <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      addr_hit <= 1'b0;
      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= 3'd0;
        sda_low <= 1'b0;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= 3'd0;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift <= byte_in;
              if (last_bit) begin
                bit_cnt <= 3'd0;
                if (byte_in[7:1] == DEV_ADDR) begin
                  addr_hit <= 1'b1;
                  busy     <= 1'b1;
                  rw       <= byte_in[0];
                  state    <= ST_ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_ADDR_ACK: begin
            // First fall asserts the ACK, second fall ends it (and starts read data if R/W=1).
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= 1'b1;
              end else if (rw) begin
                sda_low <= ~rd_data[7];
                shift   <= {rd_data[6:0], 1'b0};
                bit_cnt <= 3'd0;
                state   <= ST_RDATA;
              end else begin
                sda_low <= 1'b0;
                state   <= ST_REG;
              end
            end
          end
          ST_REG: begin
            if (scl_rise) begin
              shift <= byte_in;
              if (last_bit) begin
                bit_cnt <= 3'd0;
                ptr     <= byte_in;
                state   <= ST_REG_ACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_WDATA: begin
            if (scl_rise) begin
              shift <= byte_in;
              if (last_bit) begin
                bit_cnt  <= 3'd0;
                wr_valid <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= byte_in;
                ptr      <= ptr + 8'd1;
                state    <= ST_WDATA_ACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_REG_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!sda_low) begin
                sda_low <= 1'b1;
              end else begin
                sda_low <= 1'b0;
                state   <= ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            // Bit 7 is already on the bus at entry; each fall presents the next bit, the 8th releases.
            if (scl_fall) begin
              if (last_bit) begin
                sda_low <= 1'b0;
                ptr     <= ptr + 8'd1;
                bit_cnt <= 3'd0;
                state   <= ST_RD_MACK;
              end else begin
                sda_low <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_RD_MACK: begin
            // bit_cnt==1 marks "master ACKed, reload on the coming fall".
            if (scl_rise) begin
              if (sda_s) begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end else begin
                bit_cnt <= 3'd1;
              end
            end else if (scl_fall && (bit_cnt == 3'd1)) begin
              sda_low <= ~rd_data[7];
              shift   <= {rd_data[6:0], 1'b0};
              bit_cnt <= 3'd0;
              state   <= ST_RDATA;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regif.sv
`timescale 1ns/1ps
// Bench for i2c_slave_regif: bit-banged I2C master, register-file read model, write scoreboard.
// Latency: wr_valid is matched against queued expectations whenever the DUT pulses it.
// Backpressure: none; the master paces everything with fixed SCL quarter periods.
module tb_i2c_slave_regif;

  localparam int T = 50;  // quarter SCL period in ns (SCL high/low = 10 clock_sys cycles)

  logic       clock_sys = 1'b0;
  logic       reset_n   = 1'b0;
  logic       i2c_sclk  = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        i2c_sdat;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       addr_hit;

  int tests = 0;
  int fails = 0;
  int hits  = 0;
  logic [15:0] exp_wr[$];
  logic [15:0] exp_e;
  logic [7:0]  rbuf;

  assign i2c_sdat = m_sda_low ? 1'b0 : 1'bz;
  pullup (i2c_sdat);

  // Register-file model: each location reads back as its address plus 0x40.
  assign rd_data = rd_addr + 8'h40;

  always #5 clock_sys = ~clock_sys;

  i2c_slave_regif #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
    .clock_sys(clock_sys),
    .reset_n  (reset_n),
    .i2c_sclk (i2c_sclk),
    .i2c_sdat (i2c_sdat),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .addr_hit (addr_hit)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every wr_valid pulse must match the oldest queued expectation.
  always @(negedge clock_sys) begin
    if (addr_hit) hits++;
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        exp_e = exp_wr.pop_front();
        check("wr_txn", {wr_addr, wr_data}, exp_e);
      end
    end
  end

  task automatic bit_clk(input logic b, output logic s);
    m_sda_low = ~b;
    #T i2c_sclk = 1'b1;
    #T s = i2c_sdat;
    #T i2c_sclk = 1'b0;
    #T;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    #T i2c_sclk = 1'b1;
    #T m_sda_low = 1'b1;
    #T i2c_sclk = 1'b0;
    #T;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    #T i2c_sclk = 1'b1;
    #T m_sda_low = 1'b0;
    #(2*T);
  endtask

  task automatic send(input string nm, input logic [7:0] b, input logic exp_ack);
    logic s;
    logic a;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
    bit_clk(1'b1, a);
    check(nm, a, exp_ack);
  endtask

  task automatic rbyte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, s);
      b[i] = s;
    end
    bit_clk(mack, s);
  endtask

  initial begin
    logic s;
    // Reset state
    repeat (5) @(posedge clock_sys);
    #1;
    check("rst_wr_valid", wr_valid, 0);
    check("rst_addr_hit", addr_hit, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_sda_released", i2c_sdat, 1);
    reset_n = 1'b1;
    #(4*T);

    // Single write 0x34 0x05 0xA7
    i2c_start();
    send("t1_addr_ack", 8'h34, 1'b0);
    send("t1_reg_ack", 8'h05, 1'b0);
    exp_wr.push_back(16'h05A7);
    send("t1_data_ack", 8'hA7, 1'b0);
    check("t1_busy", busy, 1);
    i2c_stop();
    check("t1_busy_after_stop", busy, 0);
    check("t1_hits", hits, 1);

    // Burst write with pointer wrap
    i2c_start();
    send("t2_addr_ack", 8'h34, 1'b0);
    send("t2_reg_ack", 8'hFE, 1'b0);
    exp_wr.push_back(16'hFE11);
    send("t2_d0_ack", 8'h11, 1'b0);
    exp_wr.push_back(16'hFF22);
    send("t2_d1_ack", 8'h22, 1'b0);
    exp_wr.push_back(16'h0033);
    send("t2_d2_ack", 8'h33, 1'b0);
    i2c_stop();
    check("t2_ptr_wrapped", rd_addr, 8'h01);

    // Wrong device address
    i2c_start();
    send("t3_addr_nack", 8'h36, 1'b1);
    check("t3_busy", busy, 0);
    check("t3_no_hit", hits, 2);
    i2c_stop();

    // Set pointer, repeated START, read two bytes
    i2c_start();
    send("t4_addr_ack", 8'h34, 1'b0);
    send("t4_reg_ack", 8'h10, 1'b0);
    i2c_start();
    send("t4_raddr_ack", 8'h35, 1'b0);
    check("t4_busy_read", busy, 1);
    rbyte(1'b0, rbuf);
    check("t4_rd_byte0", rbuf, 8'h50);
    rbyte(1'b1, rbuf);
    check("t4_rd_byte1", rbuf, 8'h51);
    check("t4_busy_after_nack", busy, 0);
    check("t4_sda_released", i2c_sdat, 1);
    check("t4_ptr", rd_addr, 8'h12);
    i2c_stop();
    check("t4_hits", hits, 4);

    // STOP after 4 data bits, then a complete write
    i2c_start();
    send("t5_addr_ack", 8'h34, 1'b0);
    send("t5_reg_ack", 8'h20, 1'b0);
    for (int i = 0; i < 4; i++) bit_clk(i[0], s);
    i2c_stop();
    check("t5_busy_after_abort", busy, 0);
    check("t5_ptr_kept", rd_addr, 8'h20);
    i2c_start();
    send("t5b_addr_ack", 8'h34, 1'b0);
    send("t5b_reg_ack", 8'h30, 1'b0);
    exp_wr.push_back(16'h305C);
    send("t5b_data_ack", 8'h5C, 1'b0);
    i2c_stop();

    // Reset while the slave drives the address ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'h34;
      bit_clk(a[i], s);
    end
    m_sda_low = 1'b0;
    #T i2c_sclk = 1'b1;
    #T;
    check("t6_ack_driven", i2c_sdat, 0);
    check("t6_busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6_sda_released", i2c_sdat, 1);
    check("t6_busy_rst", busy, 0);
    check("t6_wr_addr_rst", wr_addr, 0);
    check("t6_wr_data_rst", wr_data, 0);
    check("t6_rd_addr_rst", rd_addr, 0);
    #T i2c_sclk = 1'b0;
    #T i2c_sclk = 1'b1;
    #T reset_n = 1'b1;
    #(2*T);
    i2c_start();
    send("t6b_addr_ack", 8'h34, 1'b0);
    send("t6b_reg_ack", 8'h42, 1'b0);
    exp_wr.push_back(16'h4299);
    send("t6b_data_ack", 8'h99, 1'b0);
    i2c_stop();

    #(4*T);
    check("final_hits", hits, 8);
    check("final_wr_queue_empty", exp_wr.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
